// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Streams a program into instruction memory one byte at a time.
//               Bytes are packed big-endian into 32-bit words, and each word
//               is written at a PC-format byte address. The processor core is
//               held in reset until a load completes cleanly.
// Config      : LOADER_CHECKSUM_EN - when defined, one extra byte follows the
//               program. It must equal the XOR of all program bytes, or the
//               load ends in ERR.
// Ports       : ProgramLoader_CLK/RST       clock, sync active-high reset
//               ProgramLoader_Start/Length  load request, word count (8b)
//               ProgramLoader_ByteIn/Valid  byte stream in
//               ProgramLoader_ByteReady     loader accepts a byte this edge
//               ProgramLoader_WE/Addr/WD    instruction-memory write port
//               ProgramLoader_CpuRST        core reset, low only when DONE
//               ProgramLoader_Busy/Done/Error  status
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 100
) (
  input  logic             ProgramLoader_CLK,
  input  logic             ProgramLoader_RST,
  input  logic             ProgramLoader_Start,
  input  logic [7:0]       ProgramLoader_Length,
  input  logic [7:0]       ProgramLoader_ByteIn,
  input  logic             ProgramLoader_ByteValid,
  output logic             ProgramLoader_ByteReady,
  output logic             ProgramLoader_WE,
  output logic [31:0]      ProgramLoader_Addr,
  output logic [WIDTH-1:0] ProgramLoader_WD,
  output logic             ProgramLoader_CpuRST,
  output logic             ProgramLoader_Busy,
  output logic             ProgramLoader_Done,
  output logic             ProgramLoader_Error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t           state_q;
  logic [7:0]       len_q;
  logic [7:0]       idx_q;
  logic [1:0]       cnt_q;
  logic [WIDTH-1:0] word_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  // ByteReady is registered, so a byte is taken on the edge where the
  // already-visible ready and the source's valid coincide.
  logic             accept_d;
  logic [WIDTH-1:0] word_d;
  logic [31:0]      len_ext_d;
  logic             len_bad_d;
  logic [7:0]       idx_next_d;
  logic             last_d;

  assign accept_d   = ProgramLoader_ByteValid & ProgramLoader_ByteReady;
  assign word_d     = {word_q[WIDTH-9:0], ProgramLoader_ByteIn};
  assign len_ext_d  = {24'd0, ProgramLoader_Length};
  assign len_bad_d  = (ProgramLoader_Length == 8'd0) || (len_ext_d > 32'(DEPTH));
  assign idx_next_d = idx_q + 8'd1;
  assign last_d     = (idx_next_d == len_q);

  always_ff @(posedge ProgramLoader_CLK) begin
    if (ProgramLoader_RST) begin
      state_q                 <= S_IDLE;
      len_q                   <= 8'd0;
      idx_q                   <= 8'd0;
      cnt_q                   <= 2'd0;
      word_q                  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q                  <= 8'd0;
`endif
      ProgramLoader_ByteReady <= 1'b0;
      ProgramLoader_WE        <= 1'b0;
      ProgramLoader_Addr      <= 32'd0;
      ProgramLoader_WD        <= '0;
      ProgramLoader_CpuRST    <= 1'b1;
      ProgramLoader_Busy      <= 1'b0;
      ProgramLoader_Done      <= 1'b0;
      ProgramLoader_Error     <= 1'b0;
    end else begin
      case (state_q)
        // DONE and ERR react to Start exactly like IDLE, so a new load can
        // follow without an intervening reset.
        S_IDLE, S_DONE, S_ERR: begin
          if (ProgramLoader_Start) begin
            ProgramLoader_CpuRST <= 1'b1;
            ProgramLoader_Done   <= 1'b0;
            if (len_bad_d) begin
              state_q                 <= S_ERR;
              ProgramLoader_Error     <= 1'b1;
              ProgramLoader_Busy      <= 1'b0;
              ProgramLoader_ByteReady <= 1'b0;
            end else begin
              state_q                 <= S_RECV;
              len_q                   <= ProgramLoader_Length;
              idx_q                   <= 8'd0;
              cnt_q                   <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
              csum_q                  <= 8'd0;
`endif
              ProgramLoader_Error     <= 1'b0;
              ProgramLoader_Busy      <= 1'b1;
              ProgramLoader_ByteReady <= 1'b1;
            end
          end
        end

        S_RECV: begin
          if (accept_d) begin
            word_q <= word_d;
            cnt_q  <= cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ ProgramLoader_ByteIn;
`endif
            if (cnt_q == 2'd3) begin
              state_q                 <= S_WRITE;
              ProgramLoader_ByteReady <= 1'b0;
              ProgramLoader_WE        <= 1'b1;
              ProgramLoader_Addr      <= {22'd0, idx_q, 2'b00};
              ProgramLoader_WD        <= word_d;
            end
          end
        end

        S_WRITE: begin
          ProgramLoader_WE <= 1'b0;
          if (last_d) begin
            // Index is left at the final word so it never reaches DEPTH.
`ifdef LOADER_CHECKSUM_EN
            state_q                 <= S_CHECK;
            ProgramLoader_ByteReady <= 1'b1;
`else
            state_q                 <= S_DONE;
            ProgramLoader_Busy      <= 1'b0;
            ProgramLoader_Done      <= 1'b1;
            ProgramLoader_CpuRST    <= 1'b0;
`endif
          end else begin
            idx_q                   <= idx_next_d;
            state_q                 <= S_RECV;
            ProgramLoader_ByteReady <= 1'b1;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept_d) begin
            ProgramLoader_ByteReady <= 1'b0;
            ProgramLoader_Busy      <= 1'b0;
            if (ProgramLoader_ByteIn == csum_q) begin
              state_q              <= S_DONE;
              ProgramLoader_Done   <= 1'b1;
              ProgramLoader_CpuRST <= 1'b0;
            end else begin
              state_q             <= S_ERR;
              ProgramLoader_Error <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state_q                 <= S_IDLE;
          ProgramLoader_ByteReady <= 1'b0;
          ProgramLoader_WE        <= 1'b0;
          ProgramLoader_Busy      <= 1'b0;
          ProgramLoader_Done      <= 1'b0;
          ProgramLoader_Error     <= 1'b0;
          ProgramLoader_CpuRST    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Randomized self-checking bench for program_loader. Expected
//               memory writes and final status come from the byte list and
//               the loading rules (big-endian packing, address = word*4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst, start, bval;
  logic [7:0]  len, bin;
  logic        rdy, we, cpu_rst, busy, done, err;
  logic [31:0] addr, wd;

  always #5 clk = ~clk;

  program_loader #(.WIDTH(32), .DEPTH(100)) dut (
    .ProgramLoader_CLK       (clk),
    .ProgramLoader_RST       (rst),
    .ProgramLoader_Start     (start),
    .ProgramLoader_Length    (len),
    .ProgramLoader_ByteIn    (bin),
    .ProgramLoader_ByteValid (bval),
    .ProgramLoader_ByteReady (rdy),
    .ProgramLoader_WE        (we),
    .ProgramLoader_Addr      (addr),
    .ProgramLoader_WD        (wd),
    .ProgramLoader_CpuRST    (cpu_rst),
    .ProgramLoader_Busy      (busy),
    .ProgramLoader_Done      (done),
    .ProgramLoader_Error     (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] wr_q[$];      // observed {addr, data} writes
  logic [7:0]  tx[$];        // bytes of the current program

  always @(negedge clk) if (!rst && we) wr_q.push_back({addr, wd});

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_we"},     {63'd0, we},      64'd0);
    check_eq({tag, "_addr"},   {32'd0, addr},    64'd0);
    check_eq({tag, "_wd"},     {32'd0, wd},      64'd0);
    check_eq({tag, "_rdy"},    {63'd0, rdy},     64'd0);
    check_eq({tag, "_status"}, {61'd0, busy, done, err}, 64'd0);
    check_eq({tag, "_cpurst"}, {63'd0, cpu_rst}, 64'd1);
  endtask

  task automatic do_start(input int l);
    @(negedge clk); start = 1'b1; len = 8'(l);
    @(negedge clk); start = 1'b0; len = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gaps);
    bit ok;
    ok = 1'b0;
    for (int g = 0; g < gaps; g++) begin
      @(negedge clk); bval = 1'b0; bin = 8'($urandom);
    end
    @(negedge clk); bin = b; bval = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (rdy) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check_eq("byte_accept_timeout", {63'd0, ok}, 64'd1);
  endtask

  task automatic end_bytes();
    @(negedge clk); bval = 1'b0;
  endtask

  task automatic wait_status(input string tag);
    for (int c = 0; c < 30; c++) begin
      if (done || err) break;
      @(negedge clk);
    end
    check_eq({tag, "_finished"}, {63'd0, done | err}, 64'd1);
  endtask

  // Expected writes: word i = tx[4i..4i+3] packed big-endian at byte addr 4i.
  task automatic check_writes(input string tag, input int n);
    logic [31:0] w;
    check_eq({tag, "_nwrites"}, 64'(wr_q.size()), 64'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      w = {tx[4*i], tx[4*i+1], tx[4*i+2], tx[4*i+3]};
      check_eq($sformatf("%s_wr%0d", tag, i), wr_q[i], {32'(4*i), w});
    end
  endtask

  // Full load of tx (4*n bytes). gapmode 0: random idle gaps, 1: alternate.
  task automatic load(input string tag, input int n, input int gapmode, input bit cs_bad);
    logic [7:0] x;
    bit         exp_ok;
    x = 8'd0;
    foreach (tx[i]) x ^= tx[i];
    wr_q.delete();
    do_start(n);
    check_eq({tag, "_busy_cpurst"}, {62'd0, busy, cpu_rst}, 64'd3);
    foreach (tx[i]) send_byte(tx[i], gapmode == 1 ? 1 : int'($urandom_range(0, 2)));
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs_bad ? (x ^ 8'h01) : x, int'($urandom_range(0, 2)));
    exp_ok = !cs_bad;
`else
    exp_ok = 1'b1;
`endif
    end_bytes();
    wait_status(tag);
    check_writes(tag, n);
    check_eq({tag, "_done_err"}, {62'd0, done, err}, {62'd0, exp_ok, !exp_ok});
    check_eq({tag, "_cpurst"},   {63'd0, cpu_rst},  {63'd0, !exp_ok});
    check_eq({tag, "_idle_outs"}, {61'd0, busy, rdy, we}, 64'd0);
  endtask

  task automatic fill_random(input int n);
    tx.delete();
    for (int i = 0; i < 4 * n; i++) tx.push_back(8'($urandom));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bval = 1'b0; len = 8'd0; bin = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Single word 0x20080005.
    tx = '{8'h20, 8'h08, 8'h00, 8'h05};
    load("len1", 1, 0, 1'b0);

    // Three words with ByteValid toggling every other cycle.
    fill_random(3);
    load("alt3", 3, 1, 1'b0);

    // Illegal lengths, entered from DONE and from ERR.
    wr_q.delete();
    do_start(0);
    check_eq("len0_status", {60'd0, err, cpu_rst, busy, done}, 64'hC);
    do_start(101);
    check_eq("len101_status", {60'd0, err, cpu_rst, busy, done}, 64'hC);
    repeat (3) @(negedge clk);
    check_eq("badlen_no_we", 64'(wr_q.size()), 64'd0);

    // Maximum length: last address (DEPTH-1)*4.
    fill_random(100);
    load("len100", 100, 0, 1'b0);

    // Start pulsed mid-load is ignored.
    fill_random(2);
    wr_q.delete();
    do_start(2);
    send_byte(tx[0], 0);
    send_byte(tx[1], 1);
    end_bytes();
    do_start(5);
    check_eq("start_ignored_busy", {63'd0, busy}, 64'd1);
    for (int i = 2; i < 8; i++) send_byte(tx[i], int'($urandom_range(0, 1)));
    end_bytes();
    wait_status("start_ignored");
    check_writes("start_ignored", 2);
    check_eq("start_ignored_done", {63'd0, done}, 64'd1);

    // Reset after 6 bytes of a 2-word load, with Start and ByteValid high.
    fill_random(2);
    wr_q.delete();
    do_start(2);
    for (int i = 0; i < 6; i++) send_byte(tx[i], 0);
    @(negedge clk); rst = 1'b1; start = 1'b1; len = 8'd1; bval = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0; start = 1'b0; bval = 1'b0;
    repeat (2) @(negedge clk);
    check_writes("midrst", 1);
    check_eq("midrst_idle", {61'd0, busy, done, err}, 64'd0);

`ifdef LOADER_CHECKSUM_EN
    tx = '{8'h01, 8'h02, 8'h03, 8'h04};
    load("cs_good", 1, 0, 1'b0);
    load("cs_bad", 1, 0, 1'b1);
`endif

    // Randomized loads.
    for (int t = 0; t < 12; t++) begin
      int n;
      n = int'($urandom_range(1, 8));
      fill_random(n);
      load($sformatf("rnd%0d", t), n, int'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
